// File: rtl/reg_file.sv
// reg_file: NUM_REGS x DATA_W register file with two combinational read ports and one write port.
// Register 0 reads as zero. Define WB_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  // Read view of every register; entry 0 is a constant so no flops are built for it.
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic              wr_en;
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      // RegWrite gates the address compare, so an unknown write_reg cannot disturb storage.
      assign wr_en = RegWrite && (write_reg == ADDR_W'(gi));
      assign reg_d = wr_en ? write_data : reg_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

`ifdef WB_BYPASS_EN
  logic wb_fwd;

  // While rst is high every register is already zero, so suppressing the forward yields 0.
  assign wb_fwd     = !rst && RegWrite && (write_reg != '0);
  assign read_data1 = (wb_fwd && (read_reg1 == write_reg)) ? write_data : regs[read_reg1];
  assign read_data2 = (wb_fwd && (read_reg2 == write_reg)) ? write_data : regs[read_reg2];
`else
  assign read_data1 = regs[read_reg1];
  assign read_data2 = regs[read_reg2];
`endif

endmodule
